// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for mem_port_arbiter.
//   arb_state_e : arbiter FSM state (idle / read outstanding)
//   arb_owner_e : which port a pending read belongs to
//   RD_LAT_MAX  : largest supported memory read latency
//   CNT_W       : width of the read-latency down-counter, $clog2(RD_LAT+1)
//                 evaluated at the largest legal RD_LAT so one width serves
//                 every legal configuration
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous memory port between instruction fetch and data
// load/store. Data normally wins; after MAX_DSTREAK consecutive data grants
// with a fetch waiting, the fetch wins once. Read data is routed back to the
// port that issued the read RD_LAT cycles after its grant.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   if_req_i / if_addr_i      fetch read request and address
//   if_gnt_o                  fetch accepted this cycle
//   if_rvalid_o / if_rdata_o  fetch read data (rdata holds last value)
//   d_req_i / d_we_i          data request, 1 = store, 0 = load
//   d_addr_i / d_wdata_i      data address and store data
//   d_gnt_o                   data request accepted this cycle
//   d_rvalid_o / d_rdata_o    load data (rdata holds last value)
//   mem_en_o / mem_we_o       memory strobe and write enable
//   mem_addr_o / mem_wdata_o  memory address and write data
//   mem_rdata_i               memory read data, RD_LAT cycles after strobe
//   busy_o                    a read is outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int RD_LAT      = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    localparam int                DS_W     = $clog2(MAX_DSTREAK + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [DS_W-1:0]   DS_MAX   = DS_W'(MAX_DSTREAK);
    localparam logic [DS_W-1:0]   DS_ONE   = DS_W'(1);
    localparam logic [DS_W-1:0]   DS_ZERO  = DS_W'(0);

    arb_state_e       state_q,   state_d;
    arb_owner_e       owner_q,   owner_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [DS_W-1:0]  dstreak_q, dstreak_d;
    logic [DW-1:0]    if_hold_q, if_hold_d;
    logic [DW-1:0]    d_hold_q,  d_hold_d;

    logic complete_s;
    logic slot_free_s;
    logic fetch_pri_s;
    logic if_win_s;
    logic d_win_s;
    logic read_gnt_s;

    // Grant decision: a slot exists in IDLE or in the read completion cycle.
    // Grants are suppressed while reset is asserted so every output is 0.
    always_comb begin
        complete_s  = (state_q == ST_RD_WAIT) && (cnt_q == CNT_ONE);
        slot_free_s = rstn && ((state_q == ST_IDLE) || complete_s);
        fetch_pri_s = (dstreak_q == DS_MAX);
        if_win_s    = slot_free_s && if_req_i && (!d_req_i || fetch_pri_s);
        d_win_s     = slot_free_s && d_req_i && !if_win_s;
        read_gnt_s  = if_win_s || (d_win_s && !d_we_i);
    end

    // Memory port and requester-facing outputs, driven from the winner.
    always_comb begin
        if_gnt_o    = if_win_s;
        d_gnt_o     = d_win_s;
        mem_en_o    = if_win_s || d_win_s;
        mem_we_o    = d_win_s && d_we_i;
        if (d_win_s) begin
            mem_addr_o = d_addr_i;
        end else if (if_win_s) begin
            mem_addr_o = if_addr_i;
        end else begin
            mem_addr_o = {AW{1'b0}};
        end
        if (d_win_s && d_we_i) begin
            mem_wdata_o = d_wdata_i;
        end else begin
            mem_wdata_o = {DW{1'b0}};
        end
        if_rvalid_o = complete_s && (owner_q == OWN_IF);
        d_rvalid_o  = complete_s && (owner_q == OWN_D);
        // Live memory data in the return cycle, captured copy afterwards.
        if (if_rvalid_o) begin
            if_rdata_o = mem_rdata_i;
        end else begin
            if_rdata_o = if_hold_q;
        end
        if (d_rvalid_o) begin
            d_rdata_o = mem_rdata_i;
        end else begin
            d_rdata_o = d_hold_q;
        end
        busy_o = (state_q == ST_RD_WAIT);
    end

    // Next-state logic for FSM, latency counter, owner and hold registers.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        if_hold_d = if_hold_q;
        d_hold_d  = d_hold_q;

        if (complete_s && (owner_q == OWN_IF)) begin
            if_hold_d = mem_rdata_i;
        end else if (complete_s) begin
            d_hold_d  = mem_rdata_i;
        end else begin
            if_hold_d = if_hold_q;
        end

        case (state_q)
            ST_IDLE, ST_RD_WAIT: begin
                if (read_gnt_s) begin
                    // New read, possibly issued in the completion cycle.
                    state_d = ST_RD_WAIT;
                    cnt_d   = CNT_LOAD;
                    owner_d = if_win_s ? OWN_IF : OWN_D;
                end else if ((state_q == ST_RD_WAIT) && !complete_s) begin
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                owner_d = OWN_IF;
            end
        endcase
    end

    // Data streak: counts data grants while a fetch waits, saturating.
    always_comb begin
        if (!if_req_i || if_win_s) begin
            dstreak_d = DS_ZERO;
        end else if (d_win_s && (dstreak_q != DS_MAX)) begin
            dstreak_d = dstreak_q + DS_ONE;
        end else begin
            dstreak_d = dstreak_q;
        end
    end

    // State registers; reset discards any outstanding read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            cnt_q     <= CNT_ZERO;
            dstreak_q <= DS_ZERO;
            if_hold_q <= {DW{1'b0}};
            d_hold_q  <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            dstreak_q <= dstreak_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiter instances (RD_LAT = 1, 3, 2) share one set of request inputs,
// each with its own synchronous memory model. Each directed step targets one
// instance; expected read data is queued when a grant is expected and popped
// when the matching rvalid is expected.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    logic [2:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [15:0] if_rdata  [3];
    logic [15:0] d_rdata   [3];
    logic [15:0] mem_addr  [3];
    logic [15:0] mem_wdata [3];
    logic [15:0] mem_rdata [3];

    logic [15:0] model [0:1023];
    logic [15:0] if_q [$];
    logic [15:0] d_q  [$];

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        logic [15:0] mem  [0:1023];
        logic [15:0] pipe [1:4];

        mem_port_arbiter #(
            .AW(16), .DW(16), .RD_LAT(LAT), .MAX_DSTREAK(4)
        ) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .if_req_i    (if_req),
            .if_addr_i   (if_addr),
            .if_gnt_o    (if_gnt[g]),
            .if_rvalid_o (if_rvalid[g]),
            .if_rdata_o  (if_rdata[g]),
            .d_req_i     (d_req),
            .d_we_i      (d_we),
            .d_addr_i    (d_addr),
            .d_wdata_i   (d_wdata),
            .d_gnt_o     (d_gnt[g]),
            .d_rvalid_o  (d_rvalid[g]),
            .d_rdata_o   (d_rdata[g]),
            .mem_en_o    (mem_en[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g]),
            .busy_o      (busy[g])
        );

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(16'(i));
            for (int i = 1; i <= 4; i++) pipe[i] <= 16'h0000;
        end

        // Synchronous memory: read data appears LAT cycles after the strobe.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:0]] <= mem_wdata[g];
            pipe[1] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][9:0]] : 16'hDEAD;
            for (int i = 2; i <= 4; i++) pipe[i] <= pipe[i-1];
        end

        assign mem_rdata[g] = pipe[LAT];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance k with the expected handshake outputs.
    task automatic cyc(input int k, input logic eig, input logic edg,
                       input logic eirv, input logic edrv, input logic ebusy);
        logic [15:0] e;
        logic [15:0] ea;
        @(negedge clk);
        chk("if_gnt",    if_gnt[k],    eig);
        chk("d_gnt",     d_gnt[k],     edg);
        chk("if_rvalid", if_rvalid[k], eirv);
        chk("d_rvalid",  d_rvalid[k],  edrv);
        chk("busy",      busy[k],      ebusy);
        chk("mem_en",    mem_en[k],    eig | edg);
        chk("mem_we",    mem_we[k],    edg & d_we);
        ea = edg ? d_addr : (eig ? if_addr : 16'h0000);
        chk("mem_addr",  mem_addr[k],  ea);
        chk("mem_wdata", mem_wdata[k], (edg && d_we) ? d_wdata : 16'h0000);
        if (eirv) begin
            if (if_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_scoreboard_empty observed=rvalid expected=none");
            end else begin
                e = if_q.pop_front();
                chk("if_rdata", if_rdata[k], e);
            end
        end
        if (edrv) begin
            if (d_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_scoreboard_empty observed=rvalid expected=none");
            end else begin
                e = d_q.pop_front();
                chk("d_rdata", d_rdata[k], e);
            end
        end
        if (eig) if_q.push_back(model[if_addr[9:0]]);
        if (edg && d_we) model[d_addr[9:0]] = d_wdata;
        if (edg && !d_we) d_q.push_back(model[d_addr[9:0]]);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = init_val(16'(i));
        rstn = 1'b0; if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;

        // Reset state with a fetch already requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_if_gnt",   if_gnt[k],   1'b0);
            chk("rst_mem_en",   mem_en[k],   1'b0);
            chk("rst_mem_addr", mem_addr[k], 16'h0000);
            chk("rst_busy",     busy[k],     1'b0);
            chk("rst_if_rdata", if_rdata[k], 16'h0000);
            chk("rst_d_rdata",  d_rdata[k],  16'h0000);
        end
        @(posedge clk); #1;
        rstn = 1'b1;

        // First active cycle grants the fetch; data one cycle later.
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);

        // Back-to-back fetches at RD_LAT=1.
        if_req = 1'b1; if_addr = 16'h0000;
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if_addr = 16'h0001;
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        if_addr = 16'h0002;
        cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        if_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("if_hold", if_rdata[0], model[2]);
        chk("if_hold_rvalid", if_rvalid[0], 1'b0);
        @(posedge clk); #1;
        idle(4);

        // Data streak: four data grants, one fetch, then data again.
        if_req = 1'b1; if_addr = 16'h0005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(6);

        // RD_LAT=3: load blocks a fetch until the completion cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0020;
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        if_req = 1'b0;
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // RD_LAT=3: store granted in the load's completion cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0201;
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        d_we = 1'b1; d_addr = 16'h0301; d_wdata = 16'h1234;
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        d_req = 1'b0; d_we = 1'b0;
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Store then load back at RD_LAT=1.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h00AB;
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        d_we = 1'b0;
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        d_req = 1'b0;
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("store_load_data", d_rdata[0], 16'h00AB);
        idle(6);

        // RD_LAT=2: reset one cycle after a load grant discards the read.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0202;
        cyc(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        d_req = 1'b0; rstn = 1'b0;
        d_q.delete();
        @(negedge clk);
        chk("rst_mid_rvalid", d_rvalid[2], 1'b0);
        chk("rst_mid_busy",   busy[2],     1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_rvalid", d_rvalid[2], 1'b0);
            chk("post_rst_rdata",  d_rdata[2],  16'h0000);
            chk("post_rst_busy",   busy[2],     1'b0);
            @(posedge clk); #1;
        end

        chk("if_q_left", if_q.size(), 0);
        chk("d_q_left",  d_q.size(),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the core's single synchronous unified memory port between instruction fetch and data load/store.
- Data accesses normally win. A streak limit lets a waiting fetch through after a bounded number of data grants.
- Read data returns to the port that issued the read, after a fixed read latency. Reads are non-overlapping except back-to-back at `RD_LAT=1`.
- Sits between the fetch/PC logic, the load/store path and the memory macro.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `RD_LAT`, 1, memory read latency in cycles, legal 1..4
- `MAX_DSTREAK`, 4, consecutive data grants allowed while a fetch waits, ≥1

Ports:
- `clk` in 1: clock
- `rstn` in 1: reset, asynchronous, active-low
- `if_req_i` in 1: fetch read request
- `if_addr_i` in AW: fetch address
- `if_gnt_o` out 1: fetch accepted this cycle
- `if_rvalid_o` out 1: fetch data valid
- `if_rdata_o` out DW: fetch data
- `d_req_i` in 1: data request
- `d_we_i` in 1: 1 = store, 0 = load
- `d_addr_i` in AW: data address
- `d_wdata_i` in DW: store data
- `d_gnt_o` out 1: data request accepted
- `d_rvalid_o` out 1: load data valid
- `d_rdata_o` out DW: load data
- `mem_en_o` out 1: memory access strobe
- `mem_we_o` out 1: memory write
- `mem_addr_o` out AW: memory address
- `mem_wdata_o` out DW: memory write data
- `mem_rdata_i` in DW: memory read data, valid `RD_LAT` cycles after the `mem_en_o` edge
- `busy_o` out 1: read outstanding

## Operation
- Request handshake:
  - Each requester holds its request and payload until it sees the grant.
  - A request dropped before grant is abandoned with no side effects.
  - At most one grant per cycle.
- Grant rule:
  - In the cycle a grant is issued, `mem_en_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are driven combinationally from the winner.
  - When there is no grant, all four are 0.
- Arbitration when both request: data wins, unless `dstreak == MAX_DSTREAK`, in which case fetch wins.
- `dstreak` counter:
  - Increments on each data grant while `if_req_i` is high.
  - Clears on a fetch grant or on any cycle with `if_req_i` low.
  - Saturates at `MAX_DSTREAK`.
- States:
  - IDLE: grants are allowed.
  - RD_WAIT: read outstanding; `owner` register is set to IF or D; `cnt` counts down from `RD_LAT`.
- Transitions:
  - IDLE → granted read → RD_WAIT, with `cnt = RD_LAT`, `owner` = winner.
  - IDLE → granted store → IDLE. A store completes in its grant cycle and produces no rvalid.
  - RD_WAIT, `cnt > 1` → decrement `cnt`. No grants in this state.
  - RD_WAIT, `cnt == 1` (completion cycle):
    - Assert the owner's rvalid. Owner's rdata = `mem_rdata_i`, captured into that port's hold register.
    - A new grant is permitted in this same cycle: read → stay in RD_WAIT reloaded; store or no grant → IDLE.
- `if_rdata_o` and `d_rdata_o` equal `mem_rdata_i` during their rvalid cycle; otherwise they show the last captured value.
- `busy_o` = (state == RD_WAIT).

## Timing
- Reset values:
  - State IDLE, `cnt` 0, `dstreak` 0, `owner` IF.
  - Hold registers 0.
  - All grant, rvalid, `mem_*` and `busy_o` outputs 0.
- Read latency: grant in cycle t → rvalid in cycle t+`RD_LAT`.
- Throughput:
  - `RD_LAT=1`: one access per cycle, back-to-back reads.
  - `RD_LAT=N`: one read per N cycles.
  - Stores: one per cycle from IDLE.
- Boundary conditions:
  - Simultaneous store request and read completion: the store is granted in the completion cycle.
  - Reset asserted mid-read: the outstanding read is discarded, and no rvalid follows reset release.
  - Request held continuously: a re-grant happens only on a cycle where the grant rule allows it.
  - The requester deasserts its request the cycle after its grant if it does not want a repeat.
  - Address and data are passed through with no wrap or width change; no arithmetic on them.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` {`ST_IDLE`, `ST_RD_WAIT`}
  - `arb_owner_e` {`OWN_IF`, `OWN_D`}
  - Localparam for the `cnt` width, `$clog2(RD_LAT+1)`.
- Single module, no sub-module required. The streak counter and latency counter are small and stay inline.

## Test plan
- Reset with `if_req_i=1`, `if_addr_i=16'h0010`; release `rstn` → `if_gnt_o`=1 in the first active cycle; `if_rvalid_o`=1 one cycle later with `if_rdata_o`=`mem[0x0010]`.
- `RD_LAT=1`, fetch of 0x0000, 0x0001, 0x0002 on consecutive cycles → three grants back-to-back; rvalids on cycles 2–4 with matching data.
- Fetch held high; data reads held high (addr 0x0100) with `MAX_DSTREAK=4` → four `d_gnt_o`, then one `if_gnt_o`, then data resumes.
- `RD_LAT=3`: load from 0x0200 granted at t → `busy_o`=1 for t+1..t+3; `d_rvalid_o` at t+3; a fetch requested at t+1 is granted at t+3.
- Store 0x00AB to 0x0300, then load from 0x0300 → `mem_we_o`=1 in the store's grant cycle; no `d_rvalid_o` for the store; the load returns 0x00AB.
- Assert `rstn`=0 one cycle after a load grant with `RD_LAT=2` → no `d_rvalid_o` after release; `d_rdata_o`=0.
